// File: rtl/miss_fill_buffer_if.sv
// miss_fill_buffer_if: bundles the three channels of the miss fill buffer
// (cache miss in, next-level request/data, line fill back to the cache).
// The slave modport is the buffer's view; master is the surrounding system.
interface miss_fill_buffer_if #(
    parameter int LADDRBITS = 26,
    parameter int WORDW     = 32,
    parameter int LINEITEMS = 16
) ();
    logic                       miss_valid;
    logic                       miss_ready;
    logic [LADDRBITS-1:0]       miss_addr;

    logic                       mem_req_valid;
    logic                       mem_req_ready;
    logic [LADDRBITS-1:0]       mem_req_addr;

    logic                       mem_rdata_valid;
    logic [WORDW-1:0]           mem_rdata;
    logic                       mem_rdata_last;

    logic                       fill_valid;
    logic                       fill_ready;
    logic [LADDRBITS-1:0]       fill_addr;
    logic [LINEITEMS*WORDW-1:0] fill_data;

    modport slave (
        input  miss_valid, miss_addr,
        output miss_ready,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready,
        input  mem_rdata_valid, mem_rdata, mem_rdata_last,
        output fill_valid, fill_addr, fill_data,
        input  fill_ready
    );

    modport master (
        output miss_valid, miss_addr,
        input  miss_ready,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready,
        output mem_rdata_valid, mem_rdata, mem_rdata_last,
        input  fill_valid, fill_addr, fill_data,
        output fill_ready
    );
endinterface

// File: rtl/miss_fill_buffer.sv
// miss_fill_buffer: queues cache line misses, fetches one line at a time from
// the next level as a word-beat burst, assembles the line and returns it to
// the cache for install.
// Build option: define MFB_MERGE_EN to merge a miss into a matching queued or
// in-flight line instead of fetching it again.
module miss_fill_buffer #(
    parameter int DEPTH     = 4,
    parameter int LADDRBITS = 26,
    parameter int WORDW     = 32,
    parameter int LINEITEMS = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    miss_fill_buffer_if.slave      bus,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(LINEITEMS);

    typedef enum logic [1:0] {IDLE, REQ, BEAT, FILL} state_t;

    state_t                     state;
    state_t                     state_next;

    logic [LADDRBITS-1:0]       q_addr [DEPTH];
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [CW-1:0]              count;

    logic [LADDRBITS-1:0]       cur_addr;
    logic [LINEITEMS*WORDW-1:0] line_q;
    logic [BW-1:0]              beat_cnt;
    logic                       drop;

    logic                       merge_hit;
    logic                       push;
    logic                       pop;
    logic                       req_fire;
    logic                       beat;
    logic                       final_beat;
    logic                       burst_end;
    logic                       len_err;

    // The queue never takes a push while full, so a push+pop pair keeps count.
    assign bus.miss_ready = (count < CW'(DEPTH));
    assign push       = bus.miss_valid && bus.miss_ready && !merge_hit && !flush;
    assign pop        = (state == IDLE) && (count != '0) && !flush;
    assign req_fire   = (state == REQ) && bus.mem_req_ready;
    assign beat       = (state == BEAT) && bus.mem_rdata_valid;
    assign final_beat = (beat_cnt == BW'(LINEITEMS - 1));
    assign burst_end  = beat && (final_beat || bus.mem_rdata_last);
    assign len_err    = beat && (final_beat != bus.mem_rdata_last);

    assign bus.mem_req_addr = cur_addr;
    assign bus.fill_addr    = cur_addr;
    assign bus.fill_data    = line_q;
    assign pending          = count + CW'(state != IDLE);

`ifdef MFB_MERGE_EN
    logic [PW-1:0] off;

    // Detect a miss already covered by a live queue entry or the line being fetched.
    always_comb begin
        merge_hit = 1'b0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if (({1'b0, off} < count) && (q_addr[i] == bus.miss_addr)) begin
                merge_hit = 1'b1;
            end
        end
        if (((state == REQ) || (state == BEAT)) && !drop && (cur_addr == bus.miss_addr)) begin
            merge_hit = 1'b1;
        end
    end
`else
    assign merge_hit = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; a request accepted in the same cycle
    // as a flush still has its burst drained (as a dropped line) so stray beats
    // cannot land in a later fetch.
    always_comb begin
        state_next        = state;
        bus.mem_req_valid = 1'b0;
        bus.fill_valid    = 1'b0;
        case (state)
            IDLE: begin
                if (pop) state_next = REQ;
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_next = BEAT;
                else if (flush)        state_next = IDLE;
            end
            BEAT: begin
                if (burst_end) state_next = (drop || flush) ? IDLE : FILL;
            end
            FILL: begin
                bus.fill_valid = 1'b1;
                if (flush || bus.fill_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Miss queue: circular buffer, flush empties it and drops any same-cycle push.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) q_addr[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_addr[wr_ptr] <= bus.miss_addr;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Line assembly: clear the line on pop so short bursts leave missing words at 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr <= '0;
            line_q   <= '0;
            beat_cnt <= '0;
            drop     <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (pop) begin
                cur_addr <= q_addr[rd_ptr];
                line_q   <= '0;
                beat_cnt <= '0;
                drop     <= 1'b0;
            end
            if (req_fire) begin
                beat_cnt <= '0;
                drop     <= flush;
            end
            if ((state == BEAT) && flush) begin
                drop <= 1'b1;
            end
            if (beat) begin
                line_q[int'(beat_cnt)*WORDW +: WORDW] <= bus.mem_rdata;
                beat_cnt <= beat_cnt + BW'(1);
            end
            if (len_err) begin
                err <= 1'b1;
            end
        end
    end
endmodule
